// File: rtl/bus_arbiter4_if.sv
// Request/grant bundle between four requesters, their consumer and the arbiter.
// The master modport is the requester/consumer side; the slave modport is the arbiter.
// No logic here: the bundle carries only the signals themselves.
interface bus_arbiter4_if;
  logic [3:0] req;
  logic       bus_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       bus_valid;
  logic       busy;

  modport master (
    output req,
    output bus_ready,
    input  gnt,
    input  sel,
    input  bus_valid,
    input  busy
  );

  modport slave (
    input  req,
    input  bus_ready,
    output gnt,
    output sel,
    output bus_valid,
    output busy
  );
endinterface

// File: rtl/bus_arbiter4.sv
// Round-robin arbiter sharing one 16-bit bus between four requesters, with bounded burst tenure.
// Latency: request to grant is 1 cycle; handover between owners has no idle bubble.
// Backpressure: a beat counts only when bus_valid & bus_ready; the owner holds while bus_ready is low.
module bus_arbiter4 #(
  parameter int MAX_BURST = 4,  // accepted beats per tenure, 1..7
  parameter int CNT_W     = 3   // 2**CNT_W must exceed MAX_BURST
) (
  input logic           clk,
  input logic           rst_n,
  bus_arbiter4_if.slave bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_gnt, w_gnt_nxt;
  logic [1:0]       r_sel, w_sel_nxt;
  logic [1:0]       r_last, w_last_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;

  logic             w_beat;
  logic             w_burst_done;
  logic             w_release;
  logic [1:0]       w_pick;
  logic [1:0]       w_base;

  // First requesting index after `base`, wrapping; `base` itself is tried last,
  // so an owner with an exhausted burst wins only when nobody else is asking.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] base);
    logic [1:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = 2'(base + 2'(k));
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // Arbitration inputs: on release the current owner becomes the new "last".
  always_comb begin
    w_beat       = r_valid & bus.bus_ready;
    w_burst_done = w_beat && (r_cnt == CNT_W'(MAX_BURST - 1));
    w_release    = (r_state == GRANT) && (!bus.req[r_sel] || w_burst_done);
    w_base       = (r_state == GRANT) ? r_sel : r_last;
    w_pick       = rr_pick(bus.req, w_base);
  end

  // Next-state and registered-output values; everything holds unless changed below.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_valid_nxt = r_valid;
    w_busy_nxt  = r_busy;
    case (r_state)
      IDLE: begin
        if (|bus.req) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = 4'b0001 << w_pick;
          w_sel_nxt   = w_pick;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_busy_nxt  = 1'b1;
        end
      end
      GRANT: begin
        if (w_release) begin
          w_last_nxt = r_sel;
          w_cnt_nxt  = '0;
          if (|bus.req) begin
            w_gnt_nxt = 4'b0001 << w_pick;
            w_sel_nxt = w_pick;
          end else begin
            // sel keeps pointing at the last owner while idle
            w_state_nxt = IDLE;
            w_gnt_nxt   = 4'b0000;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
          end
        end else if (w_beat) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = 4'b0000;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears the bus immediately, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= w_sel_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.sel       = r_sel;
  assign bus.bus_valid = r_valid;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_bus_arbiter4.sv
// Directed bench for bus_arbiter4 (MAX_BURST=4): reset, rotation, backpressure,
// early drop, async reset mid-burst and idle hold.
// Inputs change just after each falling edge; outputs are sampled on falling edges.
module tb_bus_arbiter4;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  bus_arbiter4_if u_if();

  bus_arbiter4 #(.MAX_BURST(4), .CNT_W(3)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Checks grant, select and the derived valid/busy flags together.
  task automatic check_out(input string tag, input logic [3:0] exp_gnt, input logic [1:0] exp_sel);
    check_eq({tag, " gnt"},  8'(u_if.gnt), 8'(exp_gnt));
    check_eq({tag, " sel"},  8'(u_if.sel), 8'(exp_sel));
    check_eq({tag, " vld"},  8'(u_if.bus_valid), 8'(|exp_gnt));
    check_eq({tag, " busy"}, 8'(u_if.busy), 8'(|exp_gnt));
  endtask

  // Apply inputs for one cycle; returns after the next falling edge.
  task automatic step(input logic [3:0] r, input logic rdy);
    u_if.req       = r;
    u_if.bus_ready = rdy;
    @(negedge clk);
  endtask

  logic [3:0] bp_rdy;
  logic [1:0] own;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    u_if.req       = 4'hF;
    u_if.bus_ready = 1'b1;

    // Reset state, then first grant one edge after release
    @(negedge clk);
    check_out("reset", 4'b0000, 2'd0);
    rst_n = 1'b1;
    step(4'hF, 1'b1);
    check_out("first_gnt", 4'b0001, 2'd0);

    // Full rotation with all requesting: four beats per owner, no gaps
    for (int n = 1; n <= 16; n++) begin
      step(4'hF, 1'b1);
      own = 2'((n / 4) % 4);
      check_out($sformatf("rot%0d", n), 4'b0001 << own, own);
    end

    // Early drop: owner 0 drops after two beats, requester 3 takes over
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b1);
    check_out("drop_hold", 4'b0001, 2'd0);
    step(4'b1000, 1'b1);
    check_out("drop_new", 4'b1000, 2'd3);
    // New tenure starts at cnt 0: four full beats before rotating back to 0
    for (int n = 1; n <= 3; n++) begin
      step(4'b1001, 1'b1);
      check_out($sformatf("drop_cnt%0d", n), 4'b1000, 2'd3);
    end
    step(4'b1001, 1'b1);
    check_out("drop_rot", 4'b0001, 2'd0);

    // Backpressure: requester 2 alone, ready pattern 1,0,0,1,1,1
    step(4'b0100, 1'b0);
    check_out("bp_c1", 4'b0100, 2'd2);
    bp_rdy = 4'b1001;  // cycles 1..5 ready: 1,0,0,1 then 1 below
    for (int c = 0; c < 4; c++) begin
      step(4'b0100, bp_rdy[3 - c]);
      check_out($sformatf("bp_c%0d", c + 2), 4'b0100, 2'd2);
    end
    step(4'b0100, 1'b1);
    check_out("bp_c6", 4'b0100, 2'd2);
    step(4'b0100, 1'b1);  // 4th accepted beat: release and sole-requester regrant
    check_out("bp_regrant", 4'b0100, 2'd2);
    for (int n = 1; n <= 3; n++) begin
      step(4'b0101, 1'b1);
      check_out($sformatf("bp_cnt%0d", n), 4'b0100, 2'd2);
    end
    step(4'b0101, 1'b1);
    check_out("bp_rot", 4'b0001, 2'd0);

    // Idle/hold: tenure on 2, then no requests; sel stays 2
    step(4'b0100, 1'b1);
    check_out("idle_pre", 4'b0100, 2'd2);
    step(4'b0000, 1'b1);
    check_out("idle1", 4'b0000, 2'd2);
    step(4'b0000, 1'b1);
    check_out("idle2", 4'b0000, 2'd2);
    // last=2, so requester 1 is picked from idle
    step(4'b0010, 1'b1);
    check_out("idle_exit", 4'b0010, 2'd1);

    // Async reset while gnt=0010, between edges
    u_if.req = 4'hF;
    #2 rst_n = 1'b0;
    #1;
    check_out("arst", 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(4'hF, 1'b1);
    check_out("arst_rel", 4'b0001, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
